pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised pipeline-stage register that replaces the per-stage hand-written stage latches (IF/ID, ID/EXE, EXE/MEM, MEM/WB) of the MiniMIPS32 core. It carries an arbitrary-width packed payload between two stages using a valid/ready handshake, with a 2-entry skid buffer so that `in_ready` is purely registered. It also supports a synchronous flush, NOP-payload insertion on bubbles and a saturating bubble counter for performance analysis.

## Interface
- `DATA_W`, 128: payload width in bits (the packed stage bundle: alutype, aluop, src1, src2, din, wa, wreg, whilo, mreg, retaddr, …).
- `NOP_VAL`, `{DATA_W{1'b0}}`: payload driven on `out_data` whenever `out_valid`=0; the package supplies the core's NOP bundle.
- `CNT_W`, 16: bubble-counter width.

- `cpu_clk_50M`  in  1  stage clock; all state updates on its rising edge.
- `cpu_rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  synchronous kill of all held entries (branch/exception redirect).
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  this stage can accept; registered.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  `out_data` holds a live entry.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  DATA_W  registered payload; `NOP_VAL` when not valid.
- `bubble_cnt`  out  CNT_W  cycles with `out_ready`=1 and `out_valid`=0; saturates at all-ones.

## Operation
- Storage: main slot M (drives `out_*`) and skid slot S. Accept = `in_valid`&`in_ready`; emit = `out_valid`&`out_ready`.
- States: EMPTY (M, S invalid), ONE (M valid), TWO (M, S valid). Encoded as 2 bits; `out_valid` = state≠EMPTY, `in_ready` = state≠TWO.
- EMPTY: accept -> ONE, M<=in_data. Otherwise stay.
- ONE: accept&emit -> ONE, M<=in_data. Accept only -> TWO, S<=in_data. Emit only -> EMPTY, M<=NOP_VAL.
- TWO: accept is impossible (`in_ready`=0). Emit -> ONE, M<=S. Otherwise hold.
- Order is preserved: S is never emitted before M.
- Flush (priority below reset, above everything else): next state EMPTY, M and S <= NOP_VAL. Any accept that coincides with flush is discarded. A coinciding emit is a completed transfer from the downstream side.
- Held payload is stable while `out_valid`=1 and `out_ready`=0, which is required for the valid/ready rule.
- `bubble_cnt` increments when `out_ready`=1 and `out_valid`=0, including flush cycles. It saturates at 2^CNT_W−1 and never wraps.
- Reset (async assert, sync release handled upstream): state EMPTY, `out_valid`=0, `out_data`=NOP_VAL, `in_ready`=1, S=NOP_VAL, `bubble_cnt`=0. Reset asserted mid-transfer drops all entries immediately.

## Timing
- Latency: accept in cycle N -> `out_valid`=1 with that payload from cycle N+1.
- Throughput: 1 transfer/cycle sustained while `out_ready`=1.
- `in_ready` has no combinational path from `out_ready` or `in_valid`. After a downstream stall it rises one cycle after the emit that drains TWO.
- After flush in cycle N: `out_valid`=0 and `in_ready`=1 in cycle N+1. An accept in N+1 produces output in N+2.
- `out_data` and `out_valid` are direct flop outputs, with no output muxing.

## Structure
- Shared package `pipe_pkg`:
  - per-stage bundle typedefs (IF/ID, ID/EXE, EXE/MEM, MEM/WB) with their `*_W` widths;
  - per-stage NOP constants, e.g. the ID/EXE NOP = alutype NOP, aluop SLL, zero words, wa REG_NOP, all write enables disabled;
  - state encodings EMPTY=2'b00, ONE=2'b01, TWO=2'b10.
- One sub-module `sat_counter` (CNT_W, increment enable, async clear) for `bubble_cnt`. The slot/FSM logic stays in `pipe_skid_reg`.

## Test plan
- Reset then stream: `out_ready`=1, inputs 0x1..0x8 on consecutive cycles -> outputs 0x1..0x8 one cycle later, `in_ready` constantly 1, `bubble_cnt`=1 (first empty cycle only).
- Backpressure: while streaming A, B, C, drop `out_ready` for 3 cycles after A is shown -> B goes to S, `in_ready`=0, `out_data` stays A. On release: A, B, C in order, none lost or duplicated.
- Flush while in TWO with a simultaneous `in_valid` of 0xDEAD -> next cycle `out_valid`=0, `out_data`=NOP_VAL, `in_ready`=1, and 0xDEAD never appears.
- Async reset asserted mid-cycle while in ONE -> `out_valid` falls without waiting for a clock edge, and `bubble_cnt`=0.
- Saturation with CNT_W=4: `out_ready`=1, `in_valid`=0 for 20 cycles -> `bubble_cnt` reaches 15 and holds.
- Random valid/ready for 10k cycles with DATA_W=128 against a scoreboard FIFO -> exact in-order match, and `out_data` stable whenever `out_valid`&!`out_ready`.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared stage bundles, NOP payloads and skid-register state encoding
// for the MiniMIPS32 pipeline registers.
package pipe_pkg;

  localparam logic [2:0] ALUTYPE_NOP = 3'b000;
  localparam logic [7:0] ALUOP_SLL   = 8'h11;
  localparam logic [4:0] REG_NOP     = 5'b00000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  typedef struct packed {
    logic [2:0]  alutype;
    logic [7:0]  aluop;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] din;
    logic [4:0]  wa;
    logic        wreg;
    logic        whilo;
    logic        mreg;
    logic [31:0] retaddr;
  } id_ex_t;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [4:0]  wa;
    logic        wreg;
    logic [31:0] wd;
    logic        mreg;
    logic [31:0] din;
    logic        whilo;
    logic [63:0] hilo;
  } ex_mem_t;

  typedef struct packed {
    logic [4:0]  wa;
    logic        wreg;
    logic [31:0] dreg;
    logic [3:0]  dre;
    logic        mreg;
    logic        whilo;
    logic [63:0] hilo;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

  localparam if_id_t IF_ID_NOP = '{
    pc: 32'h0, inst: 32'h0
  };

  localparam id_ex_t ID_EX_NOP = '{
    alutype: ALUTYPE_NOP,
    aluop:   ALUOP_SLL,
    src1:    32'h0,
    src2:    32'h0,
    din:     32'h0,
    wa:      REG_NOP,
    wreg:    1'b0,
    whilo:   1'b0,
    mreg:    1'b0,
    retaddr: 32'h0
  };

  localparam ex_mem_t EX_MEM_NOP = '{
    aluop: ALUOP_SLL,
    wa:    REG_NOP,
    wreg:  1'b0,
    wd:    32'h0,
    mreg:  1'b0,
    din:   32'h0,
    whilo: 1'b0,
    hilo:  64'h0
  };

  localparam mem_wb_t MEM_WB_NOP = '{
    wa:    REG_NOP,
    wreg:  1'b0,
    dreg:  32'h0,
    dre:   4'h0,
    mreg:  1'b0,
    whilo: 1'b0,
    hilo:  64'h0
  };

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } skid_st_e;

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter with asynchronous clear; used for the
// stage bubble statistic.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // count up on inc, stick at all-ones
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register with 2-entry skid buffer, flush,
// NOP insertion on bubbles and a saturating bubble counter.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 128,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
  parameter int                CNT_W   = 16
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  skid_st_e          st_q, st_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [DATA_W-1:0] s_q, s_d;
  logic              ov_q, ir_q;
  logic              acc, emit;

  assign acc  = in_valid & ir_q;
  assign emit = ov_q & out_ready;

  assign in_ready  = ir_q;
  assign out_valid = ov_q;
  assign out_data  = m_q;

  // next slot contents and occupancy; flush overrides the handshake
  always_comb begin
    st_d = st_q;
    m_d  = m_q;
    s_d  = s_q;
    if (flush) begin
      st_d = ST_EMPTY;
      m_d  = NOP_VAL;
      s_d  = NOP_VAL;
    end else begin
      unique case (st_q)
        ST_EMPTY: begin
          if (acc) begin
            st_d = ST_ONE;
            m_d  = in_data;
          end
        end
        ST_ONE: begin
          unique case (1'b1)
            acc && emit: m_d = in_data;
            acc && !emit: begin
              st_d = ST_TWO;
              s_d  = in_data;
            end
            !acc && emit: begin
              st_d = ST_EMPTY;
              m_d  = NOP_VAL;
            end
            default: ;
          endcase
        end
        ST_TWO: begin
          if (emit) begin
            st_d = ST_ONE;
            m_d  = s_q;
            s_d  = NOP_VAL;
          end
        end
        default: begin
          st_d = ST_EMPTY;
          m_d  = NOP_VAL;
          s_d  = NOP_VAL;
        end
      endcase
    end
  end

  // state, slots and the registered handshake flags
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      st_q <= ST_EMPTY;
      m_q  <= NOP_VAL;
      s_q  <= NOP_VAL;
      ov_q <= 1'b0;
      ir_q <= 1'b1;
    end else begin
      st_q <= st_d;
      m_q  <= m_d;
      s_q  <= s_d;
      ov_q <= (st_d != ST_EMPTY);
      ir_q <= (st_d != ST_TWO);
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble (
    .clk(cpu_clk_50M),
    .clr(cpu_rst),
    .inc(out_ready & ~ov_q),
    .cnt(bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed vector table, corner sequences and a random scoreboard
// run for pipe_skid_reg.
module tb_pipe_skid_reg;

  localparam int DW = 128;
  localparam logic [DW-1:0] NOPV =
    128'h0BAD_0BAD_5A5A_5A5A_C0DE_C0DE_1234_5678;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          fl;
    logic          ev;
    logic [DW-1:0] ed;
    logic          eir;
  } vec_t;

  logic          cpu_clk_50M = 1'b0;
  logic          cpu_rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [15:0]   bubble_cnt;
  logic          s_in_ready, s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [3:0]    s_bubble_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  pipe_skid_reg #(
    .DATA_W(DW), .NOP_VAL(NOPV), .CNT_W(16)
  ) u_dut (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst),
    .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .bubble_cnt(bubble_cnt)
  );

  pipe_skid_reg #(
    .DATA_W(DW), .CNT_W(4)
  ) u_sat (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst),
    .flush(flush), .in_valid(in_valid),
    .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .bubble_cnt(s_bubble_cnt)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  function automatic vec_t mk(logic iv, logic [DW-1:0] d, logic o,
                              logic f, logic ev, logic [DW-1:0] ed,
                              logic eir);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = o; v.fl = f;
    v.ev = ev; v.ed = ed; v.eir = eir;
    return v;
  endfunction

  vec_t          tv[22];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] hold;
  logic          hold_chk;

  task automatic rnd_cycle(input logic iv, input logic o);
    in_valid  = iv;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    out_ready = o;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL rnd_extra: got %h want none", out_data);
      end else begin
        chk("rnd_order", out_data, sb.pop_front());
      end
    end
    if (in_valid && in_ready) sb.push_back(in_data);
    hold_chk = out_valid && !out_ready;
    hold     = out_data;
    tick();
    if (hold_chk) begin
      chk("rnd_hold", out_data, hold);
      chk("rnd_holdv", {127'b0, out_valid}, 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      tv[i] = mk(1, DW'(i + 1), 1, 0, 1, DW'(i + 1), 1);
    tv[8]  = mk(0, 0, 1, 0, 0, NOPV, 1);
    tv[9]  = mk(1, 'hA, 1, 0, 1, 'hA, 1);
    tv[10] = mk(1, 'hB, 0, 0, 1, 'hA, 0);
    tv[11] = mk(1, 'hC, 0, 0, 1, 'hA, 0);
    tv[12] = mk(1, 'hC, 0, 0, 1, 'hA, 0);
    tv[13] = mk(1, 'hC, 1, 0, 1, 'hB, 1);
    tv[14] = mk(1, 'hC, 1, 0, 1, 'hC, 1);
    tv[15] = mk(0, 0, 1, 0, 0, NOPV, 1);
    tv[16] = mk(1, 'h11, 0, 0, 1, 'h11, 1);
    tv[17] = mk(1, 'h22, 0, 0, 1, 'h11, 0);
    tv[18] = mk(1, 'hDEAD, 1, 1, 0, NOPV, 1);
    tv[19] = mk(0, 0, 1, 0, 0, NOPV, 1);
    tv[20] = mk(1, 'h33, 1, 0, 1, 'h33, 1);
    tv[21] = mk(0, 0, 1, 0, 0, NOPV, 1);

    cpu_rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    #12;
    chk("rst_ov", {127'b0, out_valid}, 0);
    chk("rst_data", out_data, NOPV);
    chk("rst_ir", {127'b0, in_ready}, 1);
    chk("rst_bub", {112'b0, bubble_cnt}, 0);
    cpu_rst = 1'b0;
    tick();

    for (int i = 0; i < 22; i++) begin
      in_valid  = tv[i].iv;
      in_data   = tv[i].d;
      out_ready = tv[i].ordy;
      flush     = tv[i].fl;
      tick();
      chk($sformatf("v%0d_ov", i), {127'b0, out_valid}, {127'b0, tv[i].ev});
      chk($sformatf("v%0d_data", i), out_data, tv[i].ed);
      chk($sformatf("v%0d_ir", i), {127'b0, in_ready}, {127'b0, tv[i].eir});
      if (i == 8) chk("stream_bub", {112'b0, bubble_cnt}, 1);
      if (i == 21) chk("flush_bub", {112'b0, bubble_cnt}, 4);
    end
    flush = 1'b0;

    in_valid = 1'b1; in_data = 'h44; out_ready = 1'b0;
    tick();
    chk("one_ov", {127'b0, out_valid}, 1);
    in_valid = 1'b0;
    #3 cpu_rst = 1'b1;
    #1;
    chk("arst_ov", {127'b0, out_valid}, 0);
    chk("arst_data", out_data, NOPV);
    chk("arst_ir", {127'b0, in_ready}, 1);
    chk("arst_bub", {112'b0, bubble_cnt}, 0);
    #1 cpu_rst = 1'b0;
    out_ready = 1'b1;

    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("sat_%0d", k), {124'b0, s_bubble_cnt},
          DW'(k > 15 ? 15 : k));
    end
    chk("bub20", {112'b0, bubble_cnt}, 20);

    sb.delete();
    for (int c = 0; c < 10000; c++)
      rnd_cycle(1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0));
    for (int c = 0; c < 4; c++) rnd_cycle(1'b0, 1'b1);
    chk("drain_empty", DW'(sb.size()), 0);
    chk("drain_ov", {127'b0, out_valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
